// File: rtl/axi_chan_buf.sv
// Single-clock AXI channel buffer: cut-through FIFO or store-and-forward on LAST,
// with occupancy, almost-full, burst count, flush and overflow recovery.
module axi_chan_buf #(
  parameter int unsigned WIDTH     = 38,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned LAST_BIT  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   burst_cnt,
  output logic                         sf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    burst_q, burst_d;
  logic             force_q, force_d;
  logic             err_q, err_d;

  logic full, empty, push, pop, release_ok, last_in, last_out;

  always_comb begin
    full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty      = (wr_ptr_q == rd_ptr_q);
    in_ready   = ~full & ~rst & ~flush;
    release_ok = (MODE == 1) ? ((burst_q != '0) | force_q) : 1'b1;
    out_valid  = ~empty & ~flush & ~rst & release_ok;
    out_data   = mem_q[rd_ptr_q[AW-1:0]];
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    last_in    = in_data[LAST_BIT];
    last_out   = out_data[LAST_BIT];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    burst_d  = burst_q;
    force_d  = force_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      burst_d  = '0;
      force_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      if ((push && last_in) && !(pop && last_out))      burst_d = burst_q + CW'(1);
      else if (!(push && last_in) && (pop && last_out)) burst_d = burst_q - CW'(1);
      if (pop && last_out) force_d = 1'b0;
      // Full with no complete burst can never release anything: drain cut-through.
      if ((MODE == 1) && full && (burst_q == '0)) begin
        force_d = 1'b1;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      burst_q  <= '0;
      force_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      force_q  <= force_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  assign count       = count_q;
  assign burst_cnt   = burst_q;
  assign almost_full = ~rst & (count_q >= CW'(AF_THRESH));
  assign sf_err      = (MODE == 1) ? err_q : 1'b0;

endmodule
